// File: rtl/ma_packetizer_if.sv
// ---------------------------------------------------------------------------
// ma_packetizer_if
// Groups the two credit-based flit links seen by the MA packetizer.
//   Upstream (raw MA injection stream):
//     rx_i      flit valid from the source
//     credit_o  packetizer may take a flit this cycle
//     data_i    raw flit
//     target_i  mapper PE address, stable while rx_i=1
//   Downstream (local NoC input port):
//     tx_o      NoC flit valid
//     credit_i  NoC can take a flit this cycle
//     data_o    NoC flit
// Modports:
//   master : the packetizer itself
//   slave  : the surrounding environment (source + NoC router)
// ---------------------------------------------------------------------------
interface ma_packetizer_if #(
    parameter int unsigned FLIT_SIZE = 32
);
    logic                 rx_i;
    logic                 credit_o;
    logic [FLIT_SIZE-1:0] data_i;
    logic [15:0]          target_i;
    logic                 tx_o;
    logic                 credit_i;
    logic [FLIT_SIZE-1:0] data_o;

    modport master (
        input  rx_i,
        input  data_i,
        input  target_i,
        input  credit_i,
        output credit_o,
        output tx_o,
        output data_o
    );

    modport slave (
        output rx_i,
        output data_i,
        output target_i,
        output credit_i,
        input  credit_o,
        input  tx_o,
        input  data_o
    );
endinterface

// File: rtl/ma_packetizer.sv
// ---------------------------------------------------------------------------
// ma_packetizer
// Framing stage behind the MA injection stream source. The raw stream arrives
// as: mapper task image, MA descriptor, then the remaining (n-1) task images.
// Each segment is wrapped in a NoC packet addressed to the mapper PE:
//   flit0 = zero-extended target address
//   flit1 = payload length in flits
//   flit2 = service code
//   payload
// Task image = 4 info words (text, data, bss, entry) + (text+data)>>2 words.
// Descriptor = count word n + 3n+1 words.
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   bus     upstream/NoC flit links (see ma_packetizer_if)
//   done_o  sticky, set when the final flit of the last packet transfers
// ---------------------------------------------------------------------------
module ma_packetizer #(
    parameter int unsigned FLIT_SIZE    = 32,
    parameter logic [31:0] TASK_SERVICE = 32'h0000_0040,
    parameter logic [31:0] DESC_SERVICE = 32'h0000_0041
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    ma_packetizer_if.master  bus,
    output logic             done_o
);

    typedef enum logic [3:0] {
        T_COLLECT,
        T_HDR,
        T_INFO,
        T_BIN,
        D_COUNT,
        D_HDR,
        D_CNT,
        D_BODY,
        DONE
    } state_e;

    localparam logic [FLIT_SIZE-1:0] ONE  = FLIT_SIZE'(1);
    localparam logic [FLIT_SIZE-1:0] FOUR = FLIT_SIZE'(4);
    localparam logic [FLIT_SIZE-1:0] TASK_SVC = FLIT_SIZE'(TASK_SERVICE);
    localparam logic [FLIT_SIZE-1:0] DESC_SVC = FLIT_SIZE'(DESC_SERVICE);

    state_e               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [FLIT_SIZE-1:0] info_q [4];
    logic [FLIT_SIZE-1:0] info_d [4];
    logic [FLIT_SIZE-1:0] bin_words_q, bin_words_d;
    logic [FLIT_SIZE-1:0] cnt_q, cnt_d;
    logic [FLIT_SIZE-1:0] n_q, n_d;
    logic [FLIT_SIZE-1:0] remaining_q, remaining_d;
    logic [FLIT_SIZE-1:0] desc_words_q, desc_words_d;
    logic                 first_q, first_d;
    logic [FLIT_SIZE-1:0] data_q, data_d;
    logic                 done_q, done_d;

    logic                 tx_int;
    logic                 credit_int;
    logic [FLIT_SIZE-1:0] data_int;
    logic                 accept;
    logic                 xfer;
    logic [FLIT_SIZE-1:0] info_sum;
    logic [FLIT_SIZE-1:0] target_ext;
    logic [FLIT_SIZE-1:0] rem_dec;
    state_e               task_next;
    state_e               desc_next;
    logic [1:0]           idx_inc;

    assign accept     = bus.rx_i & credit_int;
    assign xfer       = tx_int & bus.credit_i;
    // Sum kept at flit width on purpose: the carry out is discarded.
    assign info_sum   = info_q[0] + info_q[1];
    assign target_ext = {{(FLIT_SIZE-16){1'b0}}, bus.target_i};
    assign idx_inc    = idx_q + 2'd1;

    // Where to go when a task image finishes. The remaining counter is at
    // least 1 whenever a task is in flight, so the decrement cannot underflow.
    assign rem_dec   = remaining_q - ONE;
    assign task_next = first_q ? D_COUNT : ((rem_dec != '0) ? T_COLLECT : DONE);
    assign desc_next = (remaining_q != '0) ? T_COLLECT : DONE;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        for (int i = 0; i < 4; i++) begin
            info_d[i] = info_q[i];
        end
        bin_words_d  = bin_words_q;
        cnt_d        = cnt_q;
        n_d          = n_q;
        remaining_d  = remaining_q;
        desc_words_d = desc_words_q;
        first_d      = first_q;
        data_d       = data_q;
        done_d       = done_q;
        tx_int       = 1'b0;
        credit_int   = 1'b0;
        data_int     = data_q;

        unique case (state_q)
            T_COLLECT: begin
                credit_int = 1'b1;
                if (accept) begin
                    info_d[idx_q] = bus.data_i;
                    idx_d         = idx_inc;
                    if (idx_q == 2'd3) begin
                        // info[0..1] already hold text/data size here.
                        bin_words_d = info_sum >> 2;
                        data_d      = target_ext;
                        idx_d       = 2'd0;
                        state_d     = T_HDR;
                    end
                end
            end

            T_HDR: begin
                tx_int = 1'b1;
                if (xfer) begin
                    unique case (idx_q)
                        2'd0: begin
                            data_d = FOUR + bin_words_q;
                            idx_d  = 2'd1;
                        end
                        2'd1: begin
                            data_d = TASK_SVC;
                            idx_d  = 2'd2;
                        end
                        default: begin
                            data_d  = info_q[0];
                            idx_d   = 2'd0;
                            state_d = T_INFO;
                        end
                    endcase
                end
            end

            T_INFO: begin
                tx_int = 1'b1;
                if (xfer) begin
                    if (idx_q != 2'd3) begin
                        data_d = info_q[idx_inc];
                        idx_d  = idx_inc;
                    end else begin
                        idx_d = 2'd0;
                        if (bin_words_q == '0) begin
                            remaining_d = rem_dec;
                            first_d     = 1'b0;
                            state_d     = task_next;
                            done_d      = (task_next == DONE);
                        end else begin
                            cnt_d   = bin_words_q;
                            state_d = T_BIN;
                        end
                    end
                end
            end

            T_BIN: begin
                tx_int     = bus.rx_i;
                credit_int = bus.credit_i;
                data_int   = bus.data_i;
                if (xfer) begin
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        remaining_d = rem_dec;
                        first_d     = 1'b0;
                        state_d     = task_next;
                        done_d      = (task_next == DONE);
                    end
                end
            end

            D_COUNT: begin
                credit_int = 1'b1;
                if (accept) begin
                    n_d          = bus.data_i;
                    remaining_d  = (bus.data_i == '0) ? '0 : (bus.data_i - ONE);
                    desc_words_d = (bus.data_i << 1) + bus.data_i + ONE;
                    data_d       = target_ext;
                    idx_d        = 2'd0;
                    state_d      = D_HDR;
                end
            end

            D_HDR: begin
                tx_int = 1'b1;
                if (xfer) begin
                    unique case (idx_q)
                        2'd0: begin
                            data_d = desc_words_q + ONE;
                            idx_d  = 2'd1;
                        end
                        2'd1: begin
                            data_d = DESC_SVC;
                            idx_d  = 2'd2;
                        end
                        default: begin
                            data_d  = n_q;
                            idx_d   = 2'd0;
                            state_d = D_CNT;
                        end
                    endcase
                end
            end

            D_CNT: begin
                tx_int = 1'b1;
                if (xfer) begin
                    // 3n+1 only reaches 0 through wrap-around; skip the body then.
                    if (desc_words_q == '0) begin
                        state_d = desc_next;
                        done_d  = (desc_next == DONE);
                    end else begin
                        cnt_d   = desc_words_q;
                        state_d = D_BODY;
                    end
                end
            end

            D_BODY: begin
                tx_int     = bus.rx_i;
                credit_int = bus.credit_i;
                data_int   = bus.data_i;
                if (xfer) begin
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d = desc_next;
                        done_d  = (desc_next == DONE);
                    end
                end
            end

            DONE: begin
                // Terminal: nothing accepted, nothing emitted.
            end

            default: begin
                state_d = T_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= T_COLLECT;
            idx_q        <= 2'd0;
            bin_words_q  <= '0;
            cnt_q        <= '0;
            n_q          <= '0;
            remaining_q  <= ONE;
            desc_words_q <= '0;
            first_q      <= 1'b1;
            data_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bin_words_q  <= bin_words_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            remaining_q  <= remaining_d;
            desc_words_q <= desc_words_d;
            first_q      <= first_d;
            data_q       <= data_d;
            done_q       <= done_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_info
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    info_q[gi] <= '0;
                end else begin
                    info_q[gi] <= info_d[gi];
                end
            end
        end
    endgenerate

    // The handshake outputs are gated by reset so that both links go quiet
    // the moment rst_ni falls, even though T_COLLECT normally grants credit.
    assign bus.tx_o     = tx_int & rst_ni;
    assign bus.credit_o = credit_int & rst_ni;
    assign bus.data_o   = data_int;
    assign done_o       = done_q;

endmodule
